// File: rtl/q_argmax.sv
// Argmax over LANES signed scores, scanning one lane per cycle after the accept.
// The result is presented on a valid/ready handshake; completed handshakes are counted.
module q_argmax #(
    parameter int LANES = 10,
    parameter int W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [LANES*W-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_class,
    output logic [W-1:0]       out_score,
    output logic [15:0]        out_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

    state_t              state_q;
    logic signed [W-1:0] lane_q [LANES];
    logic signed [W-1:0] bestScore_q;
    logic signed [W-1:0] bestScore_d;
    logic [3:0]          bestIdx_q;
    logic [3:0]          bestIdx_d;
    logic [3:0]          scanIdx_q;
    logic signed [W-1:0] laneScore;
    logic                outValid_q;
    logic [3:0]          outClass_q;
    logic [W-1:0]        outScore_q;
    logic [15:0]         outCount_q;

    // Strictly-greater replacement keeps the lower index on ties.
    always_comb begin
        laneScore   = lane_q[scanIdx_q];
        bestScore_d = bestScore_q;
        bestIdx_d   = bestIdx_q;
        if (laneScore > bestScore_q) begin
            bestScore_d = laneScore;
            bestIdx_d   = scanIdx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
            bestScore_q <= '0;
            bestIdx_q   <= '0;
            scanIdx_q   <= '0;
            outValid_q  <= 1'b0;
            outClass_q  <= '0;
            outScore_q  <= '0;
            outCount_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) lane_q[i] <= in_data[W*i +: W];
                        bestScore_q <= in_data[W-1:0];
                        bestIdx_q   <= '0;
                        scanIdx_q   <= 4'd1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    bestScore_q <= bestScore_d;
                    bestIdx_q   <= bestIdx_d;
                    if (scanIdx_q == LAST_IDX) begin
                        outValid_q <= 1'b1;
                        outClass_q <= bestIdx_d;
                        outScore_q <= bestScore_d;
                        state_q    <= DONE;
                    end else begin
                        scanIdx_q <= scanIdx_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        outCount_q <= outCount_q + 16'd1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign out_class = outClass_q;
    assign out_score = outScore_q;
    assign out_count = outCount_q;

endmodule

// File: doc/q_argmax.md
# q_argmax

Downstream consumer of the 160-bit `q` result bus produced by the top-level compute stage. Treats `q` as LANES signed W-bit scores and finds the index and value of the maximum with one sequential comparison per cycle. Presents the winning class on a valid/ready output handshake and counts completed classifications. Sits between `Top`'s `q` output and the result-reporting logic and bench monitor.

## Interface
- LANES, 10, number of score lanes in the input bus
- W, 16, width of each signed score; input bus width is LANES*W (160 at defaults)
- clk  in  1  rising-edge clock, same clock as the upstream stage
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream asserts when `in_data` holds a stable result vector
- in_data  in  LANES*W  score vector; lane i = in_data[W*i+W-1 : W*i], two's complement
- in_ready  out  1  block can accept a vector (high only in IDLE)
- out_valid  out  1  `out_class`/`out_score` are valid
- out_ready  in  1  downstream consumes the result
- out_class  out  4  index of the maximum lane (0..LANES-1)
- out_score  out  W  signed score of the winning lane
- out_count  out  16  number of completed output handshakes, wraps 0xFFFF -> 0x0000

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On an edge with in_valid & in_ready:
  - copy in_data into an internal LANES*W buffer
  - best_score <= lane 0, best_idx <= 0, scan_idx <= 1
  - go to SCAN
- SCAN: each cycle compares buffer lane scan_idx against best_score as signed values.
  - Strictly greater replaces best_score and best_idx.
  - Ties keep the lower index.
  - If scan_idx == LANES-1, go to DONE after the compare; otherwise scan_idx increments.
- DONE: out_valid=1, and out_class/out_score show best_idx/best_score.
  - Outputs hold stable while out_ready=0.
  - On an edge with out_valid & out_ready: out_count increments and the FSM returns to IDLE.
- in_data is sampled only at the accept edge. Changes on in_data during SCAN or DONE have no effect.
- No overlap: in_ready=0 in SCAN and DONE. in_valid there is ignored and not queued.
- Comparison uses full W-bit signed arithmetic. No saturation or widening is needed; 0x8000 is the most negative value.
- out_class is zero-extended from the index counter. LANES must be at most 16.

## Timing
- Reset (async assert, sync release at the next edge): state=IDLE, in_ready=1, out_valid=0, out_class=0, out_score=0, out_count=0, buffer and counters cleared.
- Accept at edge N. SCAN occupies edges N+1..N+LANES-1. out_valid rises after edge N+LANES-1, i.e. 9 cycles after accept at defaults.
- With out_ready held high: the output handshake completes at edge N+LANES, in_ready returns high the same cycle, and the next accept can happen at edge N+LANES+1. Throughput is one vector per LANES+1 cycles.
- out_valid, out_class and out_score are registered. in_ready is a function of state only, with no combinational path from in_valid or out_ready.
- out_ready asserted while not in DONE has no effect.
- rst_n asserted mid-SCAN or in DONE aborts immediately:
  - all outputs return to reset values
  - the pending result is discarded and out_count is not incremented
- out_count wraps silently after 65535 handshakes.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_class=0, out_score=0, out_count=0, and no accept occurs while in reset.
- Basic max: lanes = {0,1,2,3,4,5,0x0700,7,8,9} (lane 6 largest), out_ready=1 -> out_valid exactly 9 cycles after accept, out_class=6, out_score=0x0700, out_count=1.
- Signed/tie: all lanes 0xFFFF except lane 3 = lane 8 = 0x0002 and lane 0 = 0x8000 -> out_class=3, out_score=0x0002. Repeat with all lanes 0x8000 -> out_class=0, out_score=0x8000.
- Backpressure and input isolation: hold out_ready=0 for 20 cycles after out_valid while changing in_data and pulsing in_valid -> outputs stable, in_ready=0, no new accept; raising out_ready gives one handshake, then in_ready=1.
- Mid-scan reset: assert rst_n=0 four cycles after accept -> out_valid never rises, out_count stays 0; a fresh vector after release classifies correctly.
- Back-to-back: three vectors (max at lanes 9, 0, 5) with in_valid and out_ready held high -> results 9, 0, 5 in order, accepts spaced 11 cycles apart, out_count=3.
